// File: rtl/uart_pkg.sv
// Shared types and framing constants for the byte-level UART transmitter.
// PARITY is always enumerated; it is only reachable when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit period.
// Holding clear keeps the count at zero, so the first period after release is a full one.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_tick = (cnt == TERM);

  // Wrapping on the tick means every state entered on a bit boundary starts at zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter with a one-cycle done pulse for the upstream next-byte request.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
//
// Handshake: send is a strobe sampled every cycle; it is accepted only while the FSM is
// IDLE (including the cycle done is high), and ignored otherwise with no backpressure.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx,
  output logic                 busy,
  output logic                 done,
  output tx_state_t            state_dbg
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  tx_state_t            state_q;
  tx_state_t            state_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [2:0]           bit_cnt_q;
  logic [2:0]           bit_cnt_d;
  logic                 tx_d;
  logic                 busy_d;
  logic                 done_d;
  logic                 bit_tick;
  logic                 accept;

  assign accept    = (state_q == IDLE) && send;
  assign state_dbg = state_q;

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_q == IDLE),
    .bit_tick (bit_tick)
  );

`ifdef UART_TX_PARITY_EN
  // Parity is taken at acceptance because the shift register is consumed by DATA.
  logic parity_q;
  logic parity_d;

  always_comb begin
    parity_d = parity_q;
    if (accept) begin
      parity_d = ^data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx        <= tx_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (send) begin
          state_d = START;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_tick && (bit_cnt_q == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_tick && (bit_cnt_q == LAST_STOP)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are computed for the next cycle and registered, so tx has no path from send.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = 1'b1;
    if (accept) begin
      shift_d   = data_in;
      bit_cnt_d = '0;
    end else if (bit_tick) begin
      case (state_q)
        DATA: begin
          shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        STOP: begin
          bit_cnt_d = (bit_cnt_q == LAST_STOP) ? 3'd0 : bit_cnt_q + 3'd1;
        end
        default: begin
          bit_cnt_d = bit_cnt_q;
        end
      endcase
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (state_d == IDLE);
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at CLKS_PER_BIT=4: the driver pushes hand-written
// frames with their acceptance cycle, and a line monitor decodes tx and scores each frame.
module tb_uart_tx_serializer;
  import uart_pkg::*;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
  // Frames are written stop..start, i.e. bit 0 is the start bit.
  localparam logic [10:0] F_A5 = 11'b1_0_10100101_0;
  localparam logic [10:0] F_12 = 11'b1_0_00010010_0;
  localparam logic [10:0] F_34 = 11'b1_1_00110100_0;
  localparam logic [10:0] F_C3 = 11'b1_0_11000011_0;
  localparam logic [10:0] F_55 = 11'b1_0_01010101_0;
  localparam logic [10:0] F_07 = 11'b1_1_00000111_0;
  localparam logic [10:0] F_03 = 11'b1_0_00000011_0;
`else
  localparam int NBITS = 10;
  localparam logic [10:0] F_A5 = 11'b1_10100101_0;
  localparam logic [10:0] F_12 = 11'b1_00010010_0;
  localparam logic [10:0] F_34 = 11'b1_00110100_0;
  localparam logic [10:0] F_C3 = 11'b1_11000011_0;
  localparam logic [10:0] F_55 = 11'b1_01010101_0;
`endif

  // clock / reset
  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      send = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic      tx;
  logic      busy;
  logic      done;
  tx_state_t state_dbg;
  int        cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_serializer #(
    .CLKS_PER_BIT (CPB),
    .CNT_W        (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .send      (send),
    .data_in   (data_in),
    .tx        (tx),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // scoreboard
  logic [42:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int frames_exp = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // driver tasks: all called at posedge+#1
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic [10:0] frame, input bit expect_frame);
    send    = 1'b1;
    data_in = d;
    step(1);
    send    = 1'b0;
    if (expect_frame) begin
      exp_q.push_back({cyc[31:0], frame});
      frames_exp++;
    end
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (done === 1'b1) return;
    end
    check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  // monitor: decode each frame on tx and score it against the queue head
  initial begin
    logic [10:0] got;
    logic [42:0] ent;
    int          start_cyc;
    bit          aborted;
    bit          width_err;
    bit          ctrl_err;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || tx !== 1'b0) continue;
      start_cyc = cyc;
      got       = '0;
      aborted   = 1'b0;
      width_err = 1'b0;
      ctrl_err  = 1'b0;
      for (int b = 0; b < NBITS && !aborted; b++) begin
        for (int c = 0; c < CPB; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (rst !== 1'b0) begin
            aborted = 1'b1;
            break;
          end
          if (c == 0) got[b] = tx;
          else if (tx !== got[b]) width_err = 1'b1;
          if (busy !== 1'b1 || done !== 1'b0) ctrl_err = 1'b1;
        end
      end
      if (aborted) continue;
      @(negedge clk);
      check("done_at_frame_end", {63'd0, done}, 64'd1);
      check("busy_drop_with_done", {63'd0, busy}, 64'd0);
      check("bit_period_width", {63'd0, width_err}, 64'd0);
      check("busy_high_in_frame", {63'd0, ctrl_err}, 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_frame", {53'd0, got}, 64'd0);
      end else begin
        ent = exp_q.pop_front();
        check("frame_bits", {53'd0, got}, {53'd0, ent[10:0]});
        check("start_latency", 64'(start_cyc), {32'd0, ent[42:11]});
      end
    end
  end

  // stimulus
  initial begin
    int d0;

    // reset with send held high
    rst     = 1'b1;
    send    = 1'b1;
    data_in = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_tx", {63'd0, tx}, 64'd1);
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_done", {63'd0, done}, 64'd0);
    end
    check("reset_state", 64'(state_dbg), 64'(IDLE));
    rst  = 1'b0;
    send = 1'b0;
    step(20);
    check("no_frame_after_reset", {62'd0, busy, tx}, 64'd1);

    // single byte
    send_byte(8'hA5, F_A5, 1'b1);
    wait_done("a5");
    step(1);
    check("done_one_cycle", {63'd0, done}, 64'd0);
    step(3);

    // back-to-back: second send in the done cycle of the first
    send_byte(8'h12, F_12, 1'b1);
    wait_done("b2b_first");
    send_byte(8'h34, F_34, 1'b1);
    check("b2b_start_bit", {63'd0, tx}, 64'd0);
    wait_done("b2b_second");
    step(3);

    // send while busy is ignored
    d0 = done_cnt;
    send_byte(8'hC3, F_C3, 1'b1);
    step(10);
    send_byte(8'h00, 11'd0, 1'b0);
    wait_done("busy_send");
    step(50);
    check("one_done_for_busy_send", 64'(done_cnt - d0), 64'd1);
    check("idle_after_busy_send", {62'd0, busy, tx}, 64'd1);

    // reset during DATA bit 3 of 8'h0F
    d0 = done_cnt;
    send_byte(8'h0F, 11'd0, 1'b0);
    step(16);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("midframe_reset_tx", {63'd0, tx}, 64'd1);
    check("midframe_reset_busy", {63'd0, busy}, 64'd0);
    check("midframe_reset_state", 64'(state_dbg), 64'(IDLE));
    step(60);
    check("midframe_reset_no_done", 64'(done_cnt - d0), 64'd0);
    send_byte(8'h55, F_55, 1'b1);
    wait_done("after_reset");
    step(3);

`ifdef UART_TX_PARITY_EN
    send_byte(8'h07, F_07, 1'b1);
    wait_done("parity_07");
    step(3);
    send_byte(8'h03, F_03, 1'b1);
    wait_done("parity_03");
    step(3);
`endif

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step(1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    step(2);
    check("total_done_pulses", 64'(done_cnt), 64'(frames_exp));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Byte-level UART transmitter; sits directly downstream of the 16-bit-to-byte splitter stage.
- Accepts one byte per strobe and serializes it onto the tx line as 8N1: start bit, 8 data bits LSB-first, 1 stop bit.
- Returns a one-cycle done pulse that drives the splitter's next-byte request, so a 16-bit word leaves as two back-to-back frames.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit period; legal range 2..65535.
- CNT_W, 16, width of the baud counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- send  in  1  byte-valid strobe from the upstream splitter; sampled every cycle.
- data_in  in  8  byte to transmit; captured only on an accepted send.
- tx  out  1  serial line; idles high.
- busy  out  1  high from the cycle after acceptance until done is asserted.
- done  out  1  one-cycle pulse at the end of the stop bit; connects to the upstream next-byte request.

Behaviour:
- Reset values, applied on the first clk edge with rst=1: tx=1, busy=0, done=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
- States and transitions:
  - IDLE to START when send=1. Acceptance latches data_in into the shift register. Next cycle: tx=0, busy=1.
  - START lasts CLKS_PER_BIT cycles with tx=0, then goes to DATA.
  - DATA lasts 8 bit periods of CLKS_PER_BIT cycles each. tx = shift_reg[0]. Shift right by 1 at the end of each period. The bit counter runs 0..7 and moves to STOP after bit 7.
  - STOP lasts CLKS_PER_BIT cycles with tx=1.
  - On the last STOP cycle the block registers done=1 for exactly one cycle, drops busy, and returns to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1.
  - Cleared on entry to each state.
  - A bit boundary occurs when count == CLKS_PER_BIT-1.
- Latency:
  - send accepted at edge N gives the tx falling edge at edge N+1.
  - done is asserted during cycle N+1+10*CLKS_PER_BIT.
  - Total frame is exactly 10*CLKS_PER_BIT cycles of tx activity.
- Back-to-back frames:
  - send may be asserted in the same cycle done is high. It is accepted because the state is already IDLE in that cycle.
  - This gives zero idle gap beyond the stop bit.
- send while busy: ignored; data_in is not sampled and no error is flagged. Upstream holds no data for retry.
- send and rst together: rst wins; nothing is latched.
- Reset mid-frame: on the next edge tx returns high and the state returns to IDLE. Any partial frame is truncated and done is not pulsed.
- tx is driven from a register; no combinational path from send or data_in to tx.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It lasts CLKS_PER_BIT cycles with tx = XOR of the 8 latched data bits (even parity).
  - The frame becomes 11*CLKS_PER_BIT cycles and done shifts later by CLKS_PER_BIT.
- Undefined: the PARITY state and its XOR logic are absent and the frame is 8N1 as above.

Decomposition:
- Package uart_pkg holds:
  - enum tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - localparam DATA_BITS = 8;
  - localparam STOP_BITS = 1.
- One sub-module: uart_baud_cnt, a counter with clear and terminal-count output (bit_tick). The FSM owns the shift register and bit counter.

Test Plan:
- Reset: hold rst=1 for 3 cycles while send=1 and data_in=8'hFF -> tx=1, busy=0, done=0 throughout; no frame starts after release.
- Single byte: CLKS_PER_BIT=4, send pulse with data_in=8'hA5 -> tx sequence per 4-cycle period is 0,1,0,1,0,0,1,0,1,1. done is high at exactly cycle 41 after acceptance, for 1 cycle.
- Back-to-back: CLKS_PER_BIT=4, assert send with 8'h34 in the done cycle of a previous 8'h12 frame -> second start bit begins on the next cycle, with no extra idle period.
- Send while busy: CLKS_PER_BIT=4, pulse send with 8'h00 mid-frame of 8'hC3 -> the 8'hC3 frame is unchanged and exactly one done pulse occurs.
- Reset mid-frame: CLKS_PER_BIT=4, assert rst during DATA bit 3 of 8'h0F -> tx=1 on the next cycle, busy=0, no done pulse; a subsequent send of 8'h55 transmits correctly.
- Parity (UART_TX_PARITY_EN): CLKS_PER_BIT=4, data_in=8'h07 -> parity period tx=1; done at cycle 45. With data_in=8'h03 -> parity tx=0.
